// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter: round-robin owner of a shared 2:1 mux with bounded grants and a dead cycle per switch
module mux_share_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req0,
    input  logic             req1,
    input  logic             d0,
    input  logic             d1,
    input  logic             last0,
    input  logic             last1,
    output logic             sel,
    output logic             gnt0,
    output logic             gnt1,
    output logic             m,
    output logic             m_valid,
    output logic [CNT_W-1:0] hold_cnt,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, GAP} state_t;
    state_t           state, state_nxt, arb;
    logic             ptr, ptr_nxt, sel_nxt, m_nxt, m_valid_nxt;
    logic [CNT_W-1:0] hold_nxt, cnt_inc;
    logic             own, granted, req_x, d_x, last_x, xfer, done, entering;
    assign own      = state == GRANT1;
    assign granted  = state == GRANT0 || state == GRANT1;
    assign req_x    = own ? req1 : req0;
    assign d_x      = own ? d1 : d0;
    assign last_x   = own ? last1 : last0;
    assign xfer     = granted & req_x;
    assign cnt_inc  = hold_cnt + CNT_W'(1);
    assign done     = granted & (~req_x | last_x | cnt_inc == CNT_W'(MAX_HOLD));
    assign arb      = req0 & (~req1 | ~ptr) ? GRANT0 : req1 ? GRANT1 : IDLE;
    assign entering = ~granted & arb != IDLE;
    assign gnt0     = state == GRANT0;
    assign gnt1     = state == GRANT1;
    assign busy     = state != IDLE;
    // state and every output-feeding register, cleared asynchronously
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            sel      <= 1'b0;
            m        <= 1'b0;
            m_valid  <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            sel      <= sel_nxt;
            m        <= m_nxt;
            m_valid  <= m_valid_nxt;
            hold_cnt <= hold_nxt;
        end
    end
    // IDLE and GAP arbitrate; a grant runs until drop, last or the hold limit, then takes one GAP cycle
    always_comb begin
        state_nxt = granted ? (done ? GAP : state) : arb;
    end
    // select moves only when a grant starts; counter restarts at grant start and grant end
    always_comb begin
        sel_nxt     = entering ? arb == GRANT1 : sel;
        hold_nxt    = entering | done ? '0 : xfer ? cnt_inc : hold_cnt;
        m_nxt       = xfer ? d_x : m;
        m_valid_nxt = xfer;
        ptr_nxt     = done ? ~own : ptr;
    end
endmodule
